// File: rtl/switch_conditioner.sv
// Purpose : synchronise and debounce the raw enable/slide-switch inputs as one vector for the decoders.
// Latency : a raw change held steady reaches the outputs STABLE+2 rising edges after it is first sampled.
// Backpressure: none; free-running input conditioner, every cycle is sampled and nothing is ever stalled.
//
// Ports:
//   i_clk      - system clock, all state updates on the rising edge
//   i_reset    - synchronous active-high reset, overrides all other activity
//   i_en_raw   - raw asynchronous enable switch
//   i_sw_raw   - raw asynchronous switch bits (W wide)
//   o_enable   - debounced, registered enable for the decoder
//   o_switch   - debounced, registered switch code for the decoder
//   o_changed  - one-cycle tick, high in the cycle after o_enable/o_switch update

module switch_conditioner #(
   parameter int W      = 3,
   parameter int STABLE = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_en_raw,
   input  logic [W-1:0] i_sw_raw,
   output logic         o_enable,
   output logic [W-1:0] o_switch,
   output logic         o_changed
);

   localparam int            CW       = $clog2(STABLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // two-flop synchroniser; only r_s2 is safe to use downstream
   logic [W:0]    r_s1;
   logic [W:0]    r_s2;

   // filter state
   state_t        r_state;
   logic [W:0]    r_cand;
   logic [CW-1:0] r_cnt;
   logic [W:0]    r_out;      // {enable, switch} as currently accepted
   logic          r_changed;

   // next-state values
   state_t        w_state_nxt;
   logic [W:0]    w_cand_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [W:0]    w_out_nxt;
   logic          w_changed_nxt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= {i_en_raw, i_sw_raw};
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_cand    <= '0;
         r_cnt     <= '0;
         r_out     <= '0;
         r_changed <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cand    <= w_cand_nxt;
         r_cnt     <= w_cnt_nxt;
         r_out     <= w_out_nxt;
         r_changed <= w_changed_nxt;
      end
   end

   // The whole {enable, switch} vector is qualified as a unit: any bit
   // moving restarts the count for every bit.
   always_comb begin
      w_state_nxt   = r_state;
      w_cand_nxt    = r_cand;
      w_cnt_nxt     = r_cnt;
      w_out_nxt     = r_out;
      w_changed_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (r_s2 != r_out) begin
               w_cand_nxt  = r_s2;
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT;
            end
         end

         S_WAIT: begin
            // Bounce-back is tested first so it wins over a terminal count
            // landing in the same cycle.
            if (r_s2 == r_out) begin
               w_state_nxt = S_IDLE;
            end else if (r_s2 != r_cand) begin
               w_cand_nxt = r_s2;
               w_cnt_nxt  = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_out_nxt     = r_cand;
               w_changed_nxt = 1'b1;
               w_state_nxt   = S_IDLE;
            end else begin
               // cannot pass CNT_LAST: the branch above stops it there
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_enable  = r_out[W];
   assign o_switch  = r_out[W-1:0];
   assign o_changed = r_changed;

endmodule

// File: tb/tb_switch_conditioner.sv
// Purpose : directed-vector bench for switch_conditioner (W=3, STABLE=4) with a queue-based scoreboard.
// Latency : expected updates are queued at the edge index e0+6 where the raw value is first sampled at e0.
// Backpressure: n/a; the monitor checks every cycle, outputs must hold unless a queued update is due.

module tb_switch_conditioner;

   logic       clk;
   logic       reset;
   logic       en_raw;
   logic [2:0] sw_raw;
   logic       enable;
   logic [2:0] switch_o;
   logic       changed;

   typedef struct {
      int         at_edge;
      logic       en;
      logic [2:0] sw;
   } exp_t;

   exp_t       q[$];
   int         cyc      = 0;   // index of the most recent rising edge
   logic       rst_seen = 1'b0;
   logic [3:0] acc      = 4'b0000;
   int         n_checks = 0;
   int         n_pass   = 0;

   switch_conditioner #(
      .W      (3),
      .STABLE (4)
   ) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_en_raw  (en_raw),
      .i_sw_raw  (sw_raw),
      .o_enable  (enable),
      .o_switch  (switch_o),
      .o_changed (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (cyc >= 1) begin
         if (rst_seen) begin
            n_checks++;
            if (!enable && switch_o == 3'b000 && !changed) n_pass++;
            else $display("FAIL reset_outputs edge=%0d got en=%b sw=%b chg=%b want 0/000/0",
                          cyc, enable, switch_o, changed);
            acc = 4'b0000;
         end else if (changed) begin
            n_checks++;
            if (q.size() == 0) begin
               $display("FAIL spurious_changed edge=%0d got en=%b sw=%b want no update",
                        cyc, enable, switch_o);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.at_edge == cyc && e.en == enable && e.sw == switch_o) n_pass++;
               else $display("FAIL update edge=%0d en=%b sw=%b want edge=%0d en=%b sw=%b",
                             cyc, enable, switch_o, e.at_edge, e.en, e.sw);
               acc = {e.en, e.sw};
            end
         end else begin
            n_checks++;
            if ({enable, switch_o} == acc) n_pass++;
            else $display("FAIL hold edge=%0d got %b want %b", cyc, {enable, switch_o}, acc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // called at a falling edge; the next rising edge samples the value
   task automatic drive(input logic en, input logic [2:0] sw);
      en_raw = en;
      sw_raw = sw;
   endtask

   // raw value first sampled at edge cyc+1 lands at cyc+1+6
   task automatic expect_upd(input logic en, input logic [2:0] sw);
      exp_t e;
      e.at_edge = cyc + 7;
      e.en      = en;
      e.sw      = sw;
      q.push_back(e);
   endtask

   initial begin
      reset  = 1'b1;
      en_raw = 1'b1;
      sw_raw = 3'b111;

      // 1. reset held for three edges with all-ones input, then release
      tick(3);
      reset = 1'b0;
      expect_upd(1'b1, 3'b111);
      tick(10);

      // 2. clean changes, including the enable bit alone
      drive(1'b0, 3'b000); expect_upd(1'b0, 3'b000); tick(10);
      drive(1'b1, 3'b101); expect_upd(1'b1, 3'b101); tick(10);
      drive(1'b1, 3'b000); expect_upd(1'b1, 3'b000); tick(10);

      // 3. three-cycle glitch is rejected
      drive(1'b1, 3'b010); tick(3);
      drive(1'b1, 3'b000); tick(10);

      // 4. bit0 toggling every two cycles, then held at 001
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, (i % 2 == 0) ? 3'b001 : 3'b000);
         tick(2);
      end
      drive(1'b1, 3'b001); expect_upd(1'b1, 3'b001); tick(12);

      // 5. candidate replaced before it qualifies
      drive(1'b1, 3'b011); tick(2);
      drive(1'b1, 3'b110); expect_upd(1'b1, 3'b110); tick(12);

      // 6. reset while cnt == 2, input stays at 100
      drive(1'b1, 3'b100); tick(5);
      reset = 1'b1; tick(1);
      reset = 1'b0;
      expect_upd(1'b1, 3'b100);
      tick(12);

      // 7a. held four cycles: bounce-back coincides with terminal count
      drive(1'b1, 3'b011); tick(4);
      drive(1'b1, 3'b100); tick(10);

      // 7b. held five cycles: accepted, then the return is accepted too
      drive(1'b1, 3'b011); expect_upd(1'b1, 3'b011); tick(5);
      drive(1'b1, 3'b100); expect_upd(1'b1, 3'b100); tick(14);

      n_checks++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL pending_updates got %0d outstanding want 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Front-end conditioner for the slide-switch and enable inputs that feed the binary decoders (`decoder2`/`decoder3`). It synchronises raw asynchronous board inputs, debounces them as one vector with a counter-based stability filter, and presents registered, glitch-free `enable`/`switch` values. It also emits a one-cycle `changed` tick whenever the conditioned value updates.

## Interface

- One clock; reset is synchronous and active-high.

Parameters:
- `W`, default 3: switch vector width (3 feeds `decoder3`, 2 feeds `decoder2`).
- `STABLE`, default 4: cycles the synchronised vector must hold before it is accepted. Legal range 2..2^20.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high; has priority over all other activity.
- `en_raw`, input, 1: raw enable switch, asynchronous.
- `sw_raw`, input, W: raw switch bits, asynchronous.
- `enable`, output, 1: debounced enable, registered; drives the decoder `enable`.
- `switch`, output, W: debounced switch code, registered; drives the decoder `switch`.
- `changed`, output, 1: one-cycle pulse, asserted in the cycle after `enable`/`switch` update.

## Operation

- **Synchroniser:** `{en_raw, sw_raw}` passes through two flop stages, `s1` then `s2`, each W+1 bits. Only `s2` is used downstream.
- **Filtering:** the whole W+1-bit vector is filtered as one unit. A change in any bit restarts qualification of the whole vector.
- **Registers:**
  - `cand`, W+1 bits: the candidate value.
  - `cnt`: width clog2(STABLE).
  - State machine with two states.
- **IDLE:**
  - If `s2 != {enable, switch}`: load `cand <= s2`, `cnt <= 0`, go to WAIT.
  - Otherwise hold.
  - `changed` = 0.
- **WAIT:**
  - If `s2 == {enable, switch}` (bounce back to the accepted value): go to IDLE. No output change, no tick.
  - Else if `s2 != cand` (new candidate): `cand <= s2`, `cnt <= 0`, stay in WAIT.
  - Else if `cnt == STABLE-1`: `{enable, switch} <= cand`, `changed <= 1`, go to IDLE.
  - Else: `cnt <= cnt + 1`.
- **`changed`:** registered. It is high for exactly one cycle per accepted update and never for two consecutive cycles.
- **Counter:** `cnt` never exceeds STABLE-1 and never wraps.
- **Reset values:** `s1 = s2 = 0`, `cand = 0`, `cnt = 0`, state IDLE, `enable = 0`, `switch = 0`, `changed = 0`.
  - Reset asserted mid-WAIT abandons the candidate; outputs return to 0 in the next cycle.
  - After reset release, a nonzero raw input is qualified normally from IDLE.

## Timing

- **Latency:** take raw input first sampled at edge e0 and held constant.
  - `s2` updates at e1.
  - WAIT is entered at e2 with `cnt = 0`.
  - `cnt = k` at edge e2+k.
  - Outputs update at edge e0+STABLE+2.
  - `changed` is high from e0+STABLE+2 to e0+STABLE+3.
- **Glitch rejection:** a raw pulse that holds `s2` for fewer than STABLE+1 consecutive cycles never reaches the outputs.
- **Back-to-back changes:** once an update lands, a new raw change takes a further full STABLE+2 edges. There is no pipelining of candidates.
- **Simultaneous events:** reset overrides any acceptance in the same cycle. A bounce-back and a `cnt` terminal value in the same cycle resolve as bounce-back, because the equality check against the outputs has priority.
- **Raw-to-output path:** purely registered; no combinational path from `raw` to outputs.

## Test plan

All scenarios use W=3, STABLE=4.

1. **Reset:** hold `reset` 3 cycles with `sw_raw = 3'b111`, `en_raw = 1` → `enable = 0`, `switch = 0`, `changed = 0` throughout. After release, outputs become 1/`3'b111` at edge 6 after the first sample, with `changed = 1` for one cycle.
2. **Clean change:** from accepted 0/`3'b000`, set `en_raw = 1`, `sw_raw = 3'b101` before edge e0 → outputs become 1/`3'b101` exactly at e0+6. `changed` pulses once; a downstream `decoder3` then shows `8'b0010_0000`.
3. **Glitch:** drive `sw_raw = 3'b010` for 3 cycles, then back to `3'b000` → outputs stay `3'b000`, `changed` never asserts, FSM returns to IDLE.
4. **Bounce:** toggle bit0 every 2 cycles for 20 cycles, then hold `3'b001` → no update during toggling. Exactly one update to `3'b001` occurs 6 edges after the final transition is sampled.
5. **Candidate switch:** `3'b011` for 2 cycles, then `3'b110` held → `cnt` restarts. Output becomes `3'b110`; `3'b011` never appears.
6. **Reset mid-WAIT:** assert `reset` when `cnt = 2` while qualifying `3'b100` → next cycle outputs 0, state IDLE, `cnt` 0. After release with the input still `3'b100`, the update occurs 6 edges later.
